iter_muldiv_unit: RTL and testbench
===================================

// Module: iter_muldiv_unit
// PURPOSE
//  Iterative unsigned 8-bit multiply/divide unit in the execute stage, directly downstream of the register file.
//  Consumes RdVal/RsVal as operands; produces an 8-bit result for the RF writeValue mux.
//  Multi-cycle: busy stalls fetch/decode, and the result is written back on the done pulse.
// PARAMETERS
//  WIDTH   8   operand/result width; iteration count = WIDTH
//  CNT_W   $clog2(WIDTH+1)   iteration counter width (derived, do not override)
// PORTS
//  CLK       in   1        single clock, rising edge
//  rst_n     in   1        asynchronous, active-low reset
//  start     in   1        request; sampled only in IDLE or DONE
//  op        in   2        muldiv_op_t: MUL_LO=0, MUL_HI=1, DIV=2, MOD=3
//  opA       in   WIDTH    dividend / multiplicand (RdVal)
//  opB       in   WIDTH    divisor / multiplier (RsVal)
//  busy      out  1        high while an operation is in progress (state RUN)
//  done      out  1        one-cycle pulse: result valid, write back now
//  result    out  WIDTH    held from done until the next accepted start
//  div_zero  out  1        set with done when DIV/MOD had opB==0; cleared on next accepted start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, div_zero=0; counter, accumulators=0.
//  Reset mid-operation aborts immediately; no done is produced for the aborted op.
//  FSM states: IDLE, RUN, DONE.
//   IDLE --start--> RUN: latch op/opA/opB, clear accumulators, cnt=0, div_zero=0.
//   RUN: one step per cycle, cnt++. After step WIDTH (cnt==WIDTH-1 at edge) -> DONE.
//   DONE: done=1 for exactly this cycle. start=1 here is accepted (back-to-back) -> RUN, else -> IDLE.
//  Latency: start sampled at edge E0, done high during the cycle following edge E(WIDTH), i.e. 9 cycles for WIDTH=8.
//  start in RUN is ignored (no queueing); operand changes after E0 have no effect.
//  MUL: shift-add, 2*WIDTH product, unsigned. MUL_LO=product[WIDTH-1:0], MUL_HI=product[2W-1:W].
//  DIV/MOD: restoring shift-subtract, unsigned; DIV -> quotient, MOD -> remainder.
//  Divide by zero: RUN lasts one cycle only -> DONE; DIV result='1 (8'hFF), MOD result=opA; div_zero=1.
//  busy=1 only in RUN; busy and done are never high together.
//  result changes only on the edge entering DONE; stable in IDLE.
//  No overflow flag: MUL_HI exposes the upper byte; no truncation error reported.
// STRUCTURE
//  Package muldiv_pkg: typedef enum logic [1:0] muldiv_op_t {MUL_LO,MUL_HI,DIV,MOD};
//   typedef enum logic [1:0] md_state_t {IDLE,RUN,DONE}; localparam DBZ_QUOT='1.
//  Single module; one always_ff (async reset) for state/datapath, always_comb for next-state/step.
//  The per-iteration shift-add/shift-subtract step is a function; no sub-module needed.
// TESTING
//  1. MUL_LO 13*11 -> done at cycle 9 after start, result=8'h8F; rerun MUL_HI -> 8'h00.
//  2. MUL 200*200 (=0x9C40): MUL_LO -> 8'h40, MUL_HI -> 8'h9C; busy high for exactly 8 cycles.
//  3. DIV 200/7 -> 8'd28; MOD 200/7 -> 8'd4; 255/1 -> 255; 5/9 -> 0, MOD 5.
//  4. DIV 77/0 -> done 2 cycles after start, result=8'hFF, div_zero=1; MOD 77/0 -> 77; next start clears div_zero.
//  5. start pulsed again during RUN with other operands -> ignored, original result; start held in DONE -> second op runs, done 9 cycles later.
//  6. rst_n low at RUN cycle 4 (async, mid-cycle) -> busy/done/result/div_zero=0 at once; no done after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: opcode, FSM states, divide-by-zero fill.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package muldiv_pkg;

   // Operation select as seen on the op port.
   typedef enum logic [1:0] {
      MUL_LO = 2'd0,
      MUL_HI = 2'd1,
      DIV    = 2'd2,
      MOD    = 2'd3
   } muldiv_op_t;

   // Control FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } md_state_t;

   // Quotient fill for a zero divisor: every result bit is set to this value.
   localparam bit DBZ_QUOT = 1'b1;

endpackage

// File: rtl/iter_muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring shift-subtract), one step per cycle.
// Latency: done pulses WIDTH cycles after the start-accepting edge (1 cycle for a zero divisor).
// Backpressure: none; busy stalls upstream, and start is ignored while RUN (no queueing).
module iter_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             div_zero
);

   // One iteration of the shared datapath. {acc, mq} is a 2*WIDTH shift register:
   //  multiply: acc = running upper half, mq = multiplier shifting out LSB-first,
   //            dvs = multiplicand; the whole pair shifts right once per step.
   //  divide:   acc = partial remainder, mq = dividend shifting out MSB-first while
   //            quotient bits shift in at the bottom, dvs = divisor.
   function automatic logic [2*WIDTH-1:0] md_step(
      input logic             is_div,
      input logic [WIDTH-1:0] acc,
      input logic [WIDTH-1:0] mq,
      input logic [WIDTH-1:0] dvs
   );
      logic [WIDTH:0]       sum;
      logic [WIDTH:0]       trial;
      logic [2*WIDTH-1:0]   nxt;
      sum   = '0;
      trial = '0;
      nxt   = '0;
      if (!is_div) begin
         // Carry out of the add becomes the new top bit after the right shift.
         sum = {1'b0, acc} + (mq[0] ? {1'b0, dvs} : '0);
         nxt = {sum, mq[WIDTH-1:1]};
      end else begin
         // Previous remainder is < divisor, so the shifted trial fits in WIDTH+1 bits
         // and the restored/subtracted remainder fits back into WIDTH bits.
         trial = {acc, mq[WIDTH-1]};
         if (trial >= {1'b0, dvs}) begin
            nxt = {WIDTH'(trial - {1'b0, dvs}), mq[WIDTH-2:0], 1'b1};
         end else begin
            nxt = {trial[WIDTH-1:0], mq[WIDTH-2:0], 1'b0};
         end
      end
      return nxt;
   endfunction

   md_state_t         state_q,    state_d;
   muldiv_op_t        op_q,       op_d;
   logic [WIDTH-1:0]  acc_q,      acc_d;
   logic [WIDTH-1:0]  mq_q,       mq_d;
   logic [WIDTH-1:0]  dvs_q,      dvs_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic [WIDTH-1:0]  result_q,   result_d;
   logic              div_zero_q, div_zero_d;

   muldiv_op_t        op_in;
   logic              is_div;
   logic              dbz;
   logic              last_step;
   logic [2*WIDTH-1:0] step_res;

   assign op_in = muldiv_op_t'(op);

   // Next-state, operand capture, iteration step and result selection.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      acc_d      = acc_q;
      mq_d       = mq_q;
      dvs_d      = dvs_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      div_zero_d = div_zero_q;

      is_div    = (op_q == DIV) || (op_q == MOD);
      dbz       = is_div && (dvs_q == '0);
      last_step = (cnt_q == CNT_W'(WIDTH - 1));
      step_res  = md_step(is_div, acc_q, mq_q, dvs_q);

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               // Operands are captured here only; later port changes are ignored.
               state_d    = RUN;
               op_d       = op_in;
               acc_d      = '0;
               cnt_d      = '0;
               div_zero_d = 1'b0;
               if ((op_in == MUL_LO) || (op_in == MUL_HI)) begin
                  dvs_d = opA;
                  mq_d  = opB;
               end else begin
                  dvs_d = opB;
                  mq_d  = opA;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (dbz) begin
               // Zero divisor short-circuits: mq still holds the untouched dividend.
               state_d    = DONE;
               div_zero_d = 1'b1;
               result_d   = (op_q == DIV) ? {WIDTH{DBZ_QUOT}} : mq_q;
            end else begin
               {acc_d, mq_d} = step_res;
               cnt_d         = cnt_q + CNT_W'(1);
               if (last_step) begin
                  state_d = DONE;
                  unique case (op_q)
                     MUL_LO: result_d = step_res[WIDTH-1:0];
                     MUL_HI: result_d = step_res[2*WIDTH-1:WIDTH];
                     DIV:    result_d = step_res[WIDTH-1:0];
                     MOD:    result_d = step_res[2*WIDTH-1:WIDTH];
                  endcase
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         op_q       <= MUL_LO;
         acc_q      <= '0;
         mq_q       <= '0;
         dvs_q      <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         acc_q      <= acc_d;
         mq_q       <= mq_d;
         dvs_q      <= dvs_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         div_zero_q <= div_zero_d;
      end
   end

   // Status decodes straight from the state register so reset clears them at once.
   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign result   = result_q;
   assign div_zero = div_zero_q;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Self-checking bench for iter_muldiv_unit: directed corner cases plus randomized ops.
// Latency: expects done WIDTH edges after the accepting edge (1 edge for a zero divisor).
// Backpressure: exercises start during RUN (ignored) and start held through DONE (back-to-back).
module tb_iter_muldiv_unit;
   import muldiv_pkg::*;

   logic       CLK = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [1:0] op = 2'd0;
   logic [7:0] opA = 8'd0;
   logic [7:0] opB = 8'd0;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       div_zero;

   int nvec = 0;
   int nerr = 0;

   iter_muldiv_unit #(.WIDTH(8)) dut (
      .CLK      (CLK),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .opA      (opA),
      .opB      (opB),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .div_zero (div_zero)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench watchdog expired");
   end

   // Reference: plain unsigned arithmetic on the operands.
   function automatic void ref_model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                                     output logic [7:0] r, output logic dz, output int lat);
      int unsigned ai = a;
      int unsigned bi = b;
      int unsigned p  = ai * bi;
      dz  = (o >= 2'd2) && (b == 8'd0);
      lat = dz ? 1 : 8;
      case (o)
         2'd0:    r = 8'(p);
         2'd1:    r = 8'(p >> 8);
         2'd2:    r = (bi == 0) ? 8'hFF : 8'(ai / bi);
         default: r = (bi == 0) ? a : 8'(ai % bi);
      endcase
   endfunction

   // Launch one op, scramble the inputs after acceptance, and wait (bounded) for done.
   task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output logic dz, output int lat,
                         output int bcnt, output bit overlap);
      @(negedge CLK);
      start = 1'b1; op = o; opA = a; opB = b;
      @(posedge CLK); #1;
      start = 1'b0; op = 2'($urandom); opA = 8'($urandom); opB = 8'($urandom);
      lat = 0; bcnt = 0; overlap = 1'b0;
      if (busy) bcnt++;
      while (!done && lat < 40) begin
         @(posedge CLK); #1;
         lat++;
         if (busy) bcnt++;
         if (busy && done) overlap = 1'b1;
      end
      res = result;
      dz  = div_zero;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done); end
      nvec++; if (result !== 8'h00) begin nerr++; $display("FAIL reset_result got %h want 00", result); end
      nvec++; if (div_zero !== 1'b0) begin nerr++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
      repeat (2) @(negedge CLK);
      rst_n = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_mul();
      logic [7:0] r; logic dz; int lat; int bc; bit ov;
      run_op(MUL_LO, 8'd13, 8'd11, r, dz, lat, bc, ov);
      nvec++; if (r !== 8'h8F) begin nerr++; $display("FAIL mul_lo_13x11 got %h want 8f", r); end
      nvec++; if (lat !== 8) begin nerr++; $display("FAIL mul_latency got %0d want 8", lat); end
      run_op(MUL_HI, 8'd13, 8'd11, r, dz, lat, bc, ov);
      nvec++; if (r !== 8'h00) begin nerr++; $display("FAIL mul_hi_13x11 got %h want 00", r); end
      run_op(MUL_LO, 8'd200, 8'd200, r, dz, lat, bc, ov);
      nvec++; if (r !== 8'h40) begin nerr++; $display("FAIL mul_lo_200x200 got %h want 40", r); end
      nvec++; if (bc !== 8) begin nerr++; $display("FAIL mul_busy_cycles got %0d want 8", bc); end
      nvec++; if (ov !== 1'b0) begin nerr++; $display("FAIL busy_done_overlap got %b want 0", ov); end
      run_op(MUL_HI, 8'd200, 8'd200, r, dz, lat, bc, ov);
      nvec++; if (r !== 8'h9C) begin nerr++; $display("FAIL mul_hi_200x200 got %h want 9c", r); end
   endtask

   task automatic test_div();
      logic [1:0] ops [5] = '{DIV, MOD, DIV, DIV, MOD};
      logic [7:0] as  [5] = '{8'd200, 8'd200, 8'd255, 8'd5, 8'd5};
      logic [7:0] bs  [5] = '{8'd7, 8'd7, 8'd1, 8'd9, 8'd9};
      logic [7:0] ex  [5] = '{8'd28, 8'd4, 8'd255, 8'd0, 8'd5};
      logic [7:0] r; logic dz; int lat; int bc; bit ov;
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], as[i], bs[i], r, dz, lat, bc, ov);
         nvec++; if (r !== ex[i]) begin nerr++; $display("FAIL div_case%0d got %0d want %0d", i, r, ex[i]); end
         nvec++; if (dz !== 1'b0) begin nerr++; $display("FAIL div_case%0d_dz got %b want 0", i, dz); end
      end
   endtask

   task automatic test_div_zero();
      logic [7:0] r; logic dz; int lat; int bc; bit ov;
      int e;
      run_op(DIV, 8'd77, 8'd0, r, dz, lat, bc, ov);
      nvec++; if (r !== 8'hFF) begin nerr++; $display("FAIL dbz_div got %h want ff", r); end
      nvec++; if (dz !== 1'b1) begin nerr++; $display("FAIL dbz_flag got %b want 1", dz); end
      nvec++; if (lat !== 1) begin nerr++; $display("FAIL dbz_latency got %0d want 1", lat); end
      run_op(MOD, 8'd77, 8'd0, r, dz, lat, bc, ov);
      nvec++; if (r !== 8'd77) begin nerr++; $display("FAIL dbz_mod got %0d want 77", r); end
      nvec++; if (dz !== 1'b1) begin nerr++; $display("FAIL dbz_mod_flag got %b want 1", dz); end
      // Next accepted start must clear the flag immediately.
      @(negedge CLK);
      start = 1'b1; op = MUL_LO; opA = 8'd3; opB = 8'd4;
      @(posedge CLK); #1;
      start = 1'b0;
      nvec++; if (div_zero !== 1'b0) begin nerr++; $display("FAIL dbz_clear got %b want 0", div_zero); end
      e = 0;
      while (!done && e < 40) begin @(posedge CLK); #1; e++; end
      nvec++; if (result !== 8'd12) begin nerr++; $display("FAIL after_dbz_mul got %0d want 12", result); end
   endtask

   task automatic test_start_during_run();
      int e;
      @(negedge CLK);
      start = 1'b1; op = MUL_LO; opA = 8'd13; opB = 8'd11;
      @(posedge CLK); #1;
      start = 1'b0;
      e = 0;
      while (!done && e < 40) begin
         @(posedge CLK); #1; e++;
         if (e == 3) begin start = 1'b1; op = DIV; opA = 8'd100; opB = 8'd3; end
         if (e == 4) start = 1'b0;
      end
      nvec++; if (e !== 8) begin nerr++; $display("FAIL run_ignore_latency got %0d want 8", e); end
      nvec++; if (result !== 8'h8F) begin nerr++; $display("FAIL run_ignore_result got %h want 8f", result); end
      @(posedge CLK); #1;
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL run_ignore_no_requeue busy got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int e;
      @(negedge CLK);
      start = 1'b1; op = MUL_LO; opA = 8'd13; opB = 8'd11;
      @(posedge CLK); #1;
      op = DIV; opA = 8'd200; opB = 8'd7;   // start stays high through RUN and DONE
      e = 0;
      while (!done && e < 40) begin @(posedge CLK); #1; e++; end
      nvec++; if (e !== 8) begin nerr++; $display("FAIL b2b_first_latency got %0d want 8", e); end
      nvec++; if (result !== 8'h8F) begin nerr++; $display("FAIL b2b_first_result got %h want 8f", result); end
      @(posedge CLK); #1; e++;
      start = 1'b0;
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_accept busy got %b want 1", busy); end
      while (!done && e < 60) begin @(posedge CLK); #1; e++; end
      nvec++; if (e !== 17) begin nerr++; $display("FAIL b2b_second_edge got %0d want 17", e); end
      nvec++; if (result !== 8'd28) begin nerr++; $display("FAIL b2b_second_result got %0d want 28", result); end
   endtask

   task automatic test_random();
      logic [1:0] o; logic [7:0] a; logic [7:0] b;
      logic [7:0] er; logic edz; int elat;
      logic [7:0] r; logic dz; int lat; int bc; bit ov;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         a = 8'($urandom);
         b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
         ref_model(o, a, b, er, edz, elat);
         run_op(o, a, b, r, dz, lat, bc, ov);
         nvec++; if (r !== er) begin nerr++; $display("FAIL rand%0d op%0d a=%0d b=%0d result got %0d want %0d", i, o, a, b, r, er); end
         nvec++; if (dz !== edz) begin nerr++; $display("FAIL rand%0d div_zero got %b want %b", i, dz, edz); end
         nvec++; if (lat !== elat) begin nerr++; $display("FAIL rand%0d latency got %0d want %0d", i, lat, elat); end
         nvec++; if (bc !== elat) begin nerr++; $display("FAIL rand%0d busy_cycles got %0d want %0d", i, bc, elat); end
         if (i % 4 == 0) begin
            repeat (3) @(posedge CLK);
            #1;
            nvec++; if (result !== er) begin nerr++; $display("FAIL rand%0d idle_hold got %0d want %0d", i, result, er); end
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] r; logic dz; int lat; int bc; bit ov;
      bit seen;
      run_op(MUL_LO, 8'd13, 8'd11, r, dz, lat, bc, ov);
      @(negedge CLK);
      start = 1'b1; op = DIV; opA = 8'd200; opB = 8'd7;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (3) @(posedge CLK);
      #4;
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL midrst_pre_busy got %b want 1", busy); end
      rst_n = 1'b0;
      #1;
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy got %b want 0", busy); end
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL midrst_done got %b want 0", done); end
      nvec++; if (result !== 8'h00) begin nerr++; $display("FAIL midrst_result got %h want 00", result); end
      nvec++; if (div_zero !== 1'b0) begin nerr++; $display("FAIL midrst_div_zero got %b want 0", div_zero); end
      @(negedge CLK);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(posedge CLK); #1;
         if (done || busy) seen = 1'b1;
      end
      nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL midrst_activity_after_release got %b want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_start_during_run();
      test_back_to_back();
      test_random();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
